// File: rtl/sync_hs_pkg.sv
// Shared types and constants for the sync_handshake_arbiter slice.
package sync_hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    LOWER = 2'd2
  } hs_state_e;

  localparam int CNT_W = 16;

  function automatic int idw_f(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sync_hs_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... modulo NUM_REQ.
module sync_hs_rr_pick
  import sync_hs_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idw_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  int             idx;
  logic [IDW-1:0] idx_v;

  // Rotating priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    winner    = {IDW{1'b0}};
    any_valid = 1'b0;
    idx       = 0;
    idx_v     = {IDW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      idx_v = IDW'(idx);
      if (!any_valid && req[idx_v]) begin
        any_valid = 1'b1;
        winner    = idx_v;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/sync_handshake_arbiter.sv
// Round-robin source-side controller for a shared four-phase req/ack crossing.
// Optional acknowledge timeout is enabled with macro SYNC_HS_TIMEOUT_EN.
module sync_handshake_arbiter
  import sync_hs_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 255,
  localparam int IDW     = idw_f(NUM_REQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] rq_valid,
  output logic [NUM_REQ-1:0] rq_done,
  output logic [NUM_REQ-1:0] rq_err,
  output logic               busy,
  output logic [IDW-1:0]     owner,
  output logic               sEN,
  output logic               sD_IN,
  input  logic               ack
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("sync_handshake_arbiter: parameter out of range");
  end

  hs_state_e          state_q, state_d;
  logic               sd_in_q, sd_in_d;
  logic               sen_q, sen_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IDW-1:0]     winner_s;
  logic               any_s;
  logic [IDW-1:0]     owner_next_s;

`ifdef SYNC_HS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  sync_hs_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (rq_valid),
    .ptr       (ptr_q),
    .winner    (winner_s),
    .any_valid (any_s)
  );

  assign owner_next_s = (owner_q == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : owner_q + IDW'(1);

  // Next-state logic; sEN and the done/err vectors default low so they pulse.
  always_comb begin
    state_d = state_q;
    sd_in_d = sd_in_q;
    sen_d   = 1'b0;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done_d  = {NUM_REQ{1'b0}};
`ifdef SYNC_HS_TIMEOUT_EN
    cnt_d   = {CNT_W{1'b0}};
    err_d   = {NUM_REQ{1'b0}};
`endif
    case (state_q)
      IDLE: begin
        // A stale high ack means the far side has not settled yet.
        if (any_s && !ack) begin
          owner_d = winner_s;
          sd_in_d = 1'b1;
          sen_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = RAISE;
        end else begin
          state_d = IDLE;
        end
      end
      RAISE: begin
        if (ack) begin
          sd_in_d = 1'b0;
          sen_d   = 1'b1;
          state_d = LOWER;
        end
`ifdef SYNC_HS_TIMEOUT_EN
        else if (cnt_q == TO_LIM) begin
          err_d[owner_q] = 1'b1;
          sd_in_d        = 1'b0;
          sen_d          = sd_in_q;
          busy_d         = 1'b0;
          ptr_d          = owner_next_s;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = RAISE;
        end
`endif
      end
      LOWER: begin
        if (!ack) begin
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          ptr_d           = owner_next_s;
          state_d         = IDLE;
        end
`ifdef SYNC_HS_TIMEOUT_EN
        else if (cnt_q == TO_LIM) begin
          err_d[owner_q] = 1'b1;
          sd_in_d        = 1'b0;
          sen_d          = sd_in_q;
          busy_d         = 1'b0;
          ptr_d          = owner_next_s;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = LOWER;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        sd_in_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sd_in_q <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= {IDW{1'b0}};
      ptr_q   <= {IDW{1'b0}};
      done_q  <= {NUM_REQ{1'b0}};
`ifdef SYNC_HS_TIMEOUT_EN
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= {NUM_REQ{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      sd_in_q <= sd_in_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
`ifdef SYNC_HS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sD_IN   = sd_in_q;
  assign sEN     = sen_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign rq_done = done_q;
`ifdef SYNC_HS_TIMEOUT_EN
  assign rq_err  = err_q;
`else
  assign rq_err  = {NUM_REQ{1'b0}};
`endif

endmodule

// File: tb/tb_sync_handshake_arbiter.sv
// Self-checking bench for sync_handshake_arbiter: vector table plus multi-cycle sequences.
module tb_sync_handshake_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] rq_valid = 4'b0000;
  logic       ack = 1'b0;
  logic [3:0] rq_done, rq_err;
  logic       busy, sEN, sD_IN;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  logic echo    = 1'b0;
  logic echo_sd = 1'b0;
  logic prev_sd = 1'b0;

  sync_handshake_arbiter #(.NUM_REQ(4), .TIMEOUT(10)) dut (
    .CLK(CLK), .RST(RST), .rq_valid(rq_valid), .rq_done(rq_done), .rq_err(rq_err),
    .busy(busy), .owner(owner), .sEN(sEN), .sD_IN(sD_IN), .ack(ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       ak;
    logic       e_busy;
    logic       chk_own;
    logic [1:0] e_own;
    logic       e_sen;
    logic       e_sd;
    logic [3:0] e_done;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic a, input logic b,
                              input logic co, input logic [1:0] o, input logic s, input logic d,
                              input logic [3:0] dn);
    vec_t v;
    v.rst = r; v.rq = q; v.ak = a; v.e_busy = b; v.chk_own = co; v.e_own = o;
    v.e_sen = s; v.e_sd = d; v.e_done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sEN must track every sD_IN change except across a reset edge.
  task automatic tick();
    logic rst_at;
    rst_at = RST;
    @(posedge CLK);
    #1;
    if (!rst_at) chk("sen_vs_sd", {31'd0, sEN}, {31'd0, sD_IN != prev_sd});
    prev_sd = sD_IN;
    if (echo) begin
      ack     = echo_sd;
      echo_sd = sD_IN;
    end
  endtask

  task automatic do_reset();
    echo = 1'b0; ack = 1'b0; rq_valid = 4'b0000; RST = 1'b1;
    tick();
    RST = 1'b0; echo_sd = 1'b0;
  endtask

  initial begin
    int n_grant, n_done, rise_c, c, dcount, err_c;
    logic [1:0] last_own;

    tbl[0]  = mk(1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[1]  = mk(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[2]  = mk(1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[3]  = mk(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    tbl[4]  = mk(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000);
    tbl[5]  = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    tbl[6]  = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[7]  = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001);
    tbl[8]  = mk(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0000);
    tbl[9]  = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000);
    tbl[10] = mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100);
    tbl[11] = mk(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    tbl[12] = mk(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    tbl[13] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001);
    tbl[14] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[15] = mk(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[16] = mk(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'b0000);
    tbl[17] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000);
    tbl[18] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1000);
    tbl[19] = mk(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    tbl[20] = mk(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    tbl[21] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001);
    tbl[22] = mk(1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0000);
    tbl[23] = mk(1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    tbl[24] = mk(1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000);
    tbl[25] = mk(1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000);
    tbl[26] = mk(1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000);
    tbl[27] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001);

    for (int i = 0; i < 28; i++) begin
      RST = tbl[i].rst; rq_valid = tbl[i].rq; ack = tbl[i].ak;
      tick();
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      if (tbl[i].chk_own) chk($sformatf("v%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].e_own});
      chk($sformatf("v%0d_sen", i), {31'd0, sEN}, {31'd0, tbl[i].e_sen});
      chk($sformatf("v%0d_sd", i), {31'd0, sD_IN}, {31'd0, tbl[i].e_sd});
      chk($sformatf("v%0d_done", i), {28'd0, rq_done}, {28'd0, tbl[i].e_done});
      chk($sformatf("v%0d_err", i), {28'd0, rq_err}, 32'd0);
    end

    // Round robin with all requesters held and an echoing far side.
    do_reset();
    rq_valid = 4'b1111; echo = 1'b1;
    n_grant = 0; n_done = 0; rise_c = 0; last_own = 2'd0;
    for (c = 1; c <= 80 && n_done < 5; c++) begin
      tick();
      if (sEN && sD_IN) begin
        chk($sformatf("rr_owner%0d", n_grant), {30'd0, owner}, n_grant % 4);
        last_own = owner; rise_c = c; n_grant++;
      end
      if (rq_done != 4'b0000) begin
        chk($sformatf("rr_done%0d", n_done), {28'd0, rq_done}, 32'd1 << (n_done % 4));
        chk($sformatf("rr_lat%0d", n_done), c - rise_c, 32'd4);
        n_done++;
      end
    end
    chk("rr_done_count", n_done, 32'd5);

    // Requester 2 drops its request while its handshake is in RAISE.
    do_reset();
    rq_valid = 4'b0100; echo = 1'b1;
    tick();
    chk("drop_grant_owner", {30'd0, owner}, 32'd2);
    chk("drop_grant_sen", {31'd0, sEN}, 32'd1);
    rq_valid = 4'b0000;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rq_done != 4'b0000) begin
        dcount++;
        chk("drop_done_val", {28'd0, rq_done}, 32'h4);
      end
    end
    chk("drop_done_count", dcount, 32'd1);
    chk("drop_idle", {31'd0, busy}, 32'd0);

`ifdef SYNC_HS_TIMEOUT_EN
    // Far side never answers: abort after TIMEOUT cycles in RAISE.
    do_reset();
    rq_valid = 4'b0010; ack = 1'b0;
    tick();
    chk("to_grant_owner", {30'd0, owner}, 32'd1);
    rq_valid = 4'b0000;
    err_c = 0;
    for (c = 2; c <= 25 && err_c == 0; c++) begin
      tick();
      chk($sformatf("to_nodone_c%0d", c), {28'd0, rq_done}, 32'd0);
      if (rq_err != 4'b0000) begin
        err_c = c;
        chk("to_err_val", {28'd0, rq_err}, 32'h2);
        chk("to_err_sd", {31'd0, sD_IN}, 32'd0);
        chk("to_err_sen", {31'd0, sEN}, 32'd1);
      end
    end
    chk("to_err_cycle", err_c, 32'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
